rom_stream_reader: RTL and testbench

ROM_STREAM_READER -- requirements
Module: rom_stream_reader

---
 rtl/rom_stream_reader_if.sv | 26 ++
 rtl/rom_stream_reader.sv | 74 +++++++
 tb/tb_rom_stream_reader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if: burst request, asynchronous ROM port and downstream valid/ready stream.
interface rom_stream_reader_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
);
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] last_addr;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] checksum;
   modport master (
      output start, start_addr, last_addr, rom_data, out_ready,
      input  rom_addr, out_data, out_valid, out_last, busy, done, checksum
   );
   modport slave (
      input  start, start_addr, last_addr, rom_data, out_ready,
      output rom_addr, out_data, out_valid, out_last, busy, done, checksum
   );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: streams a wrapping address range out of an asynchronous ROM, one word per 2 cycles.
// Define ROM_STREAM_READER_CHECKSUM_EN to build the running XOR checksum; otherwise checksum is tied to 0.
module rom_stream_reader #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
) (
   input logic               clk,
   input logic               rst,
   rom_stream_reader_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              accept, xfer, at_last;
   assign accept  = state_q == IDLE && bus.start;
   assign xfer    = state_q == SEND && bus.out_ready;
   assign at_last = addr_q == last_q;
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      last_d  = last_q;
      data_d  = data_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = FETCH;
            addr_d  = bus.start_addr;
            last_d  = bus.last_addr;
         end
         FETCH: begin
            data_d  = bus.rom_data;
            state_d = SEND;
         end
         SEND: if (bus.out_ready) begin
            state_d = at_last ? DONE : FETCH;
            addr_d  = at_last ? addr_q : addr_q + ADDR_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         last_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         data_q  <= data_d;
      end
   end
   assign bus.rom_addr  = addr_q;
   assign bus.out_data  = data_q;
   assign bus.out_valid = state_q == SEND;
   assign bus.out_last  = state_q == SEND && at_last;
   assign bus.busy      = state_q != IDLE;
   assign bus.done      = state_q == DONE;
`ifdef ROM_STREAM_READER_CHECKSUM_EN
   logic [DATA_W-1:0] chk_q, chk_d;
   always_comb chk_d = accept ? '0 : (xfer ? chk_q ^ data_q : chk_q);
   always_ff @(posedge clk) begin
      if (rst) chk_q <= '0;
      else     chk_q <= chk_d;
   end
   assign bus.checksum = chk_q;
`else
   logic unused;
   assign unused       = accept ^ xfer;
   assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: directed bursts against a 16'h1111*i ROM model, checking data, timing and control.
module tb_rom_stream_reader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   always #5 clk = ~clk;
   rom_stream_reader_if #(.ADDR_W(3), .DATA_W(16)) bus ();
   rom_stream_reader #(.ADDR_W(3), .DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   assign bus.rom_data = 16'h1111 * {13'd0, bus.rom_addr};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  bus.busy, 0);
      check({tag, "_valid"}, bus.out_valid, 0);
      check({tag, "_last"},  bus.out_last, 0);
      check({tag, "_done"},  bus.done, 0);
      check({tag, "_data"},  bus.out_data, 0);
      check({tag, "_addr"},  bus.rom_addr, 0);
      check({tag, "_chk"},   bus.checksum, 0);
   endtask

   task automatic burst(input logic [2:0] s, input logic [2:0] l, input int stall, input bit abort);
      logic [2:0]  a = s;
      logic [2:0]  d = l - s;
      int          n = int'(d) + 1;
      logic [15:0] x = '0;
      logic [15:0] w;
      int          k;
      bus.out_ready  = (stall == 0);
      bus.start      = 1'b1;
      bus.start_addr = s;
      bus.last_addr  = l;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < n; i++) begin
         k = 1;
         while (!bus.out_valid && k < 8) begin
            @(negedge clk);
            k++;
         end
         w = 16'h1111 * {13'd0, a};
         x ^= w;
         check("latency", k, 2);
         check("data", bus.out_data, w);
         check("last", bus.out_last, i == n - 1);
         check("busy", bus.busy, 1);
         if (abort && i == 1) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_idle("abort");
            repeat (3) begin
               @(negedge clk);
               check("abort_nodone", bus.done, 0);
               check("abort_busy", bus.busy, 0);
            end
            return;
         end
         if (i == 1) begin
            bus.start      = 1'b1;
            bus.start_addr = s + 3'd3;
            bus.last_addr  = s + 3'd3;
         end
         if (i == 0 && stall > 0) begin
            repeat (stall) begin
               @(negedge clk);
               check("hold_valid", bus.out_valid, 1);
               check("hold_data", bus.out_data, w);
               check("hold_last", bus.out_last, n == 1);
            end
            bus.out_ready = 1'b1;
         end
         @(negedge clk);
         bus.start = 1'b0;
         a++;
      end
      check("done", bus.done, 1);
      check("done_valid", bus.out_valid, 0);
      check("done_busy", bus.busy, 1);
`ifdef ROM_STREAM_READER_CHECKSUM_EN
      check("checksum", bus.checksum, x);
`else
      check("checksum", bus.checksum, 0);
`endif
      bus.start      = 1'b1;
      bus.start_addr = 3'd0;
      bus.last_addr  = 3'd0;
      @(negedge clk);
      bus.start = 1'b0;
      check("done_pulse", bus.done, 0);
      check("done_start_ignored", bus.busy, 0);
      @(negedge clk);
      check("stay_idle", bus.busy, 0);
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.start_addr = '0;
      bus.last_addr  = '0;
      bus.out_ready  = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);
      burst(3'd0, 3'd7, 0, 1'b0);
      burst(3'd6, 3'd6, 0, 1'b0);
      burst(3'd6, 3'd1, 0, 1'b0);
      burst(3'd0, 3'd1, 5, 1'b0);
      burst(3'd0, 3'd7, 0, 1'b1);
      burst(3'd2, 3'd3, 0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
